// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder: 128x32 data memory for the single-cycle MIPS core with
// optional post-reset clear sweep (DMEM_INIT_CLEAR_EN) and saturating access
// counters.  Rev 1.0
// ============================================================================
module data_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              READY,
  output logic [CNT_W-1:0]  RD_CNT,
  output logic [CNT_W-1:0]  WR_CNT
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              ready;
  logic              rd_acc;
  logic              wr_acc;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;

  // Sweep one word per edge; the edge that clears the last word opens the port.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_ADDR) begin
        state_d = ST_SERVE;
        ready_d = 1'b1;
      end
    end
  end

  assign ready = ready_q;
`else
  assign ready = 1'b1;
`endif

  // An X/Z on CEN makes these conditions unknown, which the counter update treats as idle.
  assign rd_acc = ready & (CEN == 1'b0) & WEN & ~OEN;
  assign wr_acc = ready & (CEN == 1'b0) & ~WEN;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_acc && (rd_cnt_q != {CNT_W{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (wr_acc && (wr_cnt_q != {CNT_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = A;
    mem_wdata = D;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == ST_INIT) begin
      mem_we    = ~RST;
      mem_addr  = ptr_q;
      mem_wdata = '0;
    end else begin
      mem_we = wr_acc;
    end
`else
    mem_we = wr_acc;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`ifdef DMEM_INIT_CLEAR_EN
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      ready_q  <= 1'b0;
`endif
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`ifdef DMEM_INIT_CLEAR_EN
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
`endif
    end
  end

  // Array has no reset so contents survive RST (and can be preloaded).
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign Q      = rd_acc ? mem_q[A] : '0;
  assign READY  = ready;
  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_data_mem_responder: scoreboard bench for data_mem_responder (CNT_W=4 build),
// covering both DMEM_INIT_CLEAR_EN builds.
module tb_data_mem_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DMEM_INIT_CLEAR_EN
  localparam logic EXP_READY_RST = 1'b0;
`else
  localparam logic EXP_READY_RST = 1'b1;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              CEN, WEN, OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  wire  [DATA_W-1:0] Q;
  wire               READY;
  wire  [CNT_W-1:0]  RD_CNT;
  wire  [CNT_W-1:0]  WR_CNT;

  data_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .OEN(OEN),
    .A(A), .D(D), .Q(Q), .READY(READY), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic        m_ready;
  int          m_rd, m_wr;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
  endtask

  // One port cycle: called just after a posedge, checks Q at the negedge,
  // then lets the next posedge commit and updates the model.
  task automatic access(input logic cen, input logic wen, input logic oen,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input string tag);
    exp_t e, got_e;
    CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
    e.tag = tag;
    e.val = (m_ready && !cen && wen && !oen) ? model_mem[a] : 32'h0;
    sb.push_back(e);
    @(negedge CLK);
    got_e = sb.pop_front();
    check(got_e.tag, Q, got_e.val);
    @(posedge CLK);
    if (m_ready && !cen && !wen) begin
      model_mem[a] = d;
      m_wr = (m_wr == CNT_MAX) ? CNT_MAX : m_wr + 1;
    end
    if (m_ready && !cen && wen && !oen) begin
      m_rd = (m_rd == CNT_MAX) ? CNT_MAX : m_rd + 1;
    end
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rd"}, {28'h0, RD_CNT}, m_rd);
    check({tag, "_wr"}, {28'h0, WR_CNT}, m_wr);
  endtask

  // Asserts RST between edges: READY and counters must clear without a clock edge.
  task automatic async_reset_check(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    idle();
    m_rd = 0; m_wr = 0; m_ready = EXP_READY_RST;
    #1;
    check({tag, "_ready"}, {31'h0, READY}, {31'h0, EXP_READY_RST});
    check_counts(tag);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  // Runs n sweep edges after RST release; optionally tries a write at edge 3.
  task automatic sweep_edges(input int n, input bit init_write);
    for (int e = 1; e <= n; e++) begin
      if (init_write && e == 3) begin
        CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'h10; D = 32'hFFFF_FFFF;
      end else begin
        idle();
      end
      @(posedge CLK);
      #1;
      if (e == 1 || e == 64 || e == DEPTH - 1 || e == DEPTH || e == n) begin
        check($sformatf("ready_edge%0d", e), {31'h0, READY}, {31'h0, (e == DEPTH)});
      end
    end
    idle();
    if (n == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      m_ready = 1'b1;
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    idle();
    m_rd = 0; m_wr = 0; m_ready = EXP_READY_RST;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", {31'h0, READY}, {31'h0, EXP_READY_RST});
    check_counts("rst_cnt");
    check("rst_q", Q, 32'h0);
    RST = 1'b0;

`ifdef DMEM_INIT_CLEAR_EN
    sweep_edges(DEPTH, 1'b1);
    access(1'b0, 1'b1, 1'b0, 7'h00, 32'h0, "clr_rd_00");
    access(1'b0, 1'b1, 1'b0, 7'h3F, 32'h0, "clr_rd_3f");
    access(1'b0, 1'b1, 1'b0, 7'h7F, 32'h0, "clr_rd_7f");
    access(1'b0, 1'b1, 1'b0, 7'h10, 32'h0, "init_wr_ignored");
    check("init_wr_cnt", {28'h0, WR_CNT}, 32'h0);
    check_counts("after_clr");
    async_reset_check("async_mid_op");
    sweep_edges(60, 1'b0);
    RST = 1'b1;
    #1;
    check("midsweep_ready", {31'h0, READY}, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sweep_edges(DEPTH, 1'b0);
`endif

    access(1'b0, 1'b0, 1'b1, 7'h05, 32'hDEAD_BEEF, "wr5_q");
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0, "rd5");
    check_counts("wr_rd");
    access(1'b0, 1'b1, 1'b1, 7'h05, 32'h0, "rd5_oen_off");
    check("oen_rd_cnt", {28'h0, RD_CNT}, m_rd);
    access(1'b1, 1'b0, 1'b0, 7'h05, 32'h1234_5678, "cen_off_wr");
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0, "rd5_kept");
    access(1'b0, 1'b0, 1'b0, 7'h06, 32'hCAFE_F00D, "wr6_oen_on_q");
    access(1'b0, 1'b1, 1'b0, 7'h06, 32'h0, "rd6");
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0, "rd5_again");
    check_counts("gating");

    async_reset_check("async_rst");
`ifdef DMEM_INIT_CLEAR_EN
    sweep_edges(DEPTH, 1'b0);
`endif
    for (int i = 0; i < 20; i++) begin
      access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0, "sat_rd");
      if (i == 13 || i == 14 || i == 19) begin
        check_counts($sformatf("sat%0d", i));
      end
    end
    check("sat_rd_max", {28'h0, RD_CNT}, 32'hF);
    check("sat_wr_zero", {28'h0, WR_CNT}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
